// File: rtl/jtdd2_snd_pkg.sv
// rtl/jtdd2_snd_pkg.sv - shared types and helpers for the DD2 sound post-processing stage
package jtdd2_snd_pkg;

  localparam logic [7:0] GAIN_UNITY = 8'h10;

  typedef enum logic {
    OUT_PRIME = 1'b0,
    OUT_RUN   = 1'b1
  } out_state_t;

  typedef enum logic [1:0] {
    PIPE_IDLE = 2'd0,
    PIPE_DC   = 2'd1,
    PIPE_MUL  = 2'd2,
    PIPE_PUSH = 2'd3
  } pipe_state_t;

  // Clamp a 32-bit signed value to the range of a w-bit signed number.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic logic sat_hit(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/jtdd2_snd_fifo.sv
// rtl/jtdd2_snd_fifo.sv - small synchronous FIFO with occupancy output
module jtdd2_snd_fifo #(
  parameter int W       = 16,
  parameter int FIFO_AW = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [W-1:0]         wdata,
  input  logic                 pop,
  output logic [W-1:0]         head,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_AW:0]     level
);

  logic [W-1:0]   mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jtdd2_snd_post.sv
// rtl/jtdd2_snd_post.sv - DC block, master gain and output-rate retiming for DD2 sound
module jtdd2_snd_post
  import jtdd2_snd_pkg::*;
#(
  parameter int W         = 16,
  parameter int DCW       = 8,
  parameter int FIFO_AW   = 2,
  parameter int PRIME_LVL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample,
  input  logic signed [W-1:0] sound_in,
  input  logic                mute,
  input  logic [7:0]          gain,
  input  logic                cen_out,
  output logic signed [W-1:0] snd_out,
  output logic                snd_valid,
  output logic                clip,
  output logic                overrun,
  output logic                underrun,
  input  logic                clr_flags
);

  localparam int YW = W + 2;

  pipe_state_t         pipe_st, pipe_nxt;
  out_state_t          out_st, out_nxt;
  logic signed [W-1:0] x, x_prev, y_prev, p;
  logic signed [YW-1:0] y_full;
  logic signed [31:0]  g_s, prod;
  logic                push, pop, full, empty;
  logic [W-1:0]        head;
  logic [FIFO_AW:0]    level;
  logic                clip_set, ovr_set, udr_set;

  always_comb begin
    y_full = YW'(x) - YW'(x_prev) + YW'(y_prev) - YW'(y_prev >>> DCW);
    g_s    = {24'd0, gain};
    prod   = (32'(y_prev) * g_s) >>> 4;
  end

  always_comb begin
    pipe_nxt = pipe_st;
    push     = 1'b0;
    ovr_set  = sample && (pipe_st != PIPE_IDLE);
    clip_set = 1'b0;
    case (pipe_st)
      PIPE_IDLE: if (sample) pipe_nxt = PIPE_DC;
      PIPE_DC:   pipe_nxt = PIPE_MUL;
      PIPE_MUL: begin
        pipe_nxt = PIPE_PUSH;
        clip_set = sat_hit(prod, W);
      end
      PIPE_PUSH: begin
        pipe_nxt = PIPE_IDLE;
        push     = 1'b1;
        // A full FIFO drops the value even if a pop happens this cycle.
        if (full) ovr_set = 1'b1;
      end
      default:   pipe_nxt = PIPE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_st <= PIPE_IDLE;
      x       <= '0;
      x_prev  <= '0;
      y_prev  <= '0;
      p       <= '0;
    end else begin
      pipe_st <= pipe_nxt;
      if (pipe_st == PIPE_IDLE && sample) x <= mute ? '0 : sound_in;
      if (pipe_st == PIPE_DC) begin
        y_prev <= W'(saturate(32'(y_full), W));
        x_prev <= x;
      end
      if (pipe_st == PIPE_MUL) p <= W'(saturate(prod, W));
    end
  end

  jtdd2_snd_fifo #(.W(W), .FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (p),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    out_nxt = out_st;
    pop     = 1'b0;
    udr_set = 1'b0;
    case (out_st)
      OUT_PRIME: if (level >= (FIFO_AW+1)'(PRIME_LVL)) out_nxt = OUT_RUN;
      OUT_RUN: begin
        if (cen_out) begin
          if (empty) begin
            udr_set = 1'b1;
            out_nxt = OUT_PRIME;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: out_nxt = OUT_PRIME;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_st    <= OUT_PRIME;
      snd_out   <= '0;
      snd_valid <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      out_st    <= out_nxt;
      snd_valid <= cen_out;
      if (pop) snd_out <= head;
      clip      <= clip_set | (clip     & ~clr_flags);
      overrun   <= ovr_set  | (overrun  & ~clr_flags);
      underrun  <= udr_set  | (underrun & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_jtdd2_snd_post.sv
// tb/tb_jtdd2_snd_post.sv - directed self-checking bench for jtdd2_snd_post
module tb_jtdd2_snd_post;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sample = 1'b0;
  logic signed [15:0] sound_in = '0;
  logic               mute = 1'b0;
  logic [7:0]         gain = 8'h10;
  logic               cen_out = 1'b0;
  logic signed [15:0] snd_out;
  logic               snd_valid, clip, overrun, underrun;
  logic               clr_flags = 1'b0;

  int total = 0;
  int bad   = 0;

  jtdd2_snd_post dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (sample),
    .sound_in  (sound_in),
    .mute      (mute),
    .gain      (gain),
    .cen_out   (cen_out),
    .snd_out   (snd_out),
    .snd_valid (snd_valid),
    .clip      (clip),
    .overrun   (overrun),
    .underrun  (underrun),
    .clr_flags (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sample = 1'b0;
    cen_out = 1'b0;
    clr_flags = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic signed [15:0] v);
    sound_in = v;
    sample = 1'b1;
    tick();
    sample = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic cen_pulse(output logic signed [15:0] o, output logic v);
    cen_out = 1'b1;
    tick();
    cen_out = 1'b0;
    o = snd_out;
    v = snd_valid;
    tick();
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic signed [15:0] o;
    logic v;
    do_reset();
    total++;
    if ({snd_out, snd_valid, clip, overrun, underrun} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs: got out=%0d v=%b c=%b o=%b u=%b want all 0",
               snd_out, snd_valid, clip, overrun, underrun);
    end
    cen_pulse(o, v);
    total++;
    if (v !== 1'b1 || o !== 16'sd0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_cen: got out=%0d v=%b u=%b want out=0 v=1 u=0", o, v, underrun);
    end
  endtask

  task automatic test_dc();
    logic signed [15:0] o;
    logic v;
    logic signed [15:0] exp_v [3];
    exp_v[0] = 16'sd1000; exp_v[1] = 16'sd997; exp_v[2] = 16'sd994;
    do_reset();
    gain = 8'h10;
    for (int i = 0; i < 3; i++) send(16'sd1000);
    for (int i = 0; i < 3; i++) begin
      cen_pulse(o, v);
      total++;
      if (o !== exp_v[i] || v !== 1'b1) begin
        bad++;
        $display("FAIL dc_out%0d: got %0d v=%b want %0d v=1", i, o, v, exp_v[i]);
      end
    end
    total++;
    if ({clip, overrun, underrun} !== 3'b000) begin
      bad++;
      $display("FAIL dc_flags: got %b%b%b want 000", clip, overrun, underrun);
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] o;
    logic v;
    do_reset();
    gain = 8'h40;
    send(16'sd10000);
    send(16'sd10000);
    cen_pulse(o, v);
    total++;
    if (o !== 16'sd32767 || clip !== 1'b1) begin
      bad++;
      $display("FAIL sat_pos: got %0d clip=%b want 32767 clip=1", o, clip);
    end
    pulse_clr();
    total++;
    if (clip !== 1'b0) begin
      bad++;
      $display("FAIL sat_clr: got clip=%b want 0", clip);
    end
    do_reset();
    send(-16'sd10000);
    send(-16'sd10000);
    cen_pulse(o, v);
    total++;
    if (o !== -16'sd32768 || clip !== 1'b1) begin
      bad++;
      $display("FAIL sat_neg: got %0d clip=%b want -32768 clip=1", o, clip);
    end
    gain = 8'h10;
  endtask

  task automatic test_underrun();
    logic signed [15:0] o;
    logic v;
    do_reset();
    gain = 8'h10;
    send(16'sd100);
    send(16'sd200);
    cen_pulse(o, v);
    total++;
    if (o !== 16'sd100) begin bad++; $display("FAIL udr_a: got %0d want 100", o); end
    cen_pulse(o, v);
    total++;
    if (o !== 16'sd200 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL udr_b: got %0d u=%b want 200 u=0", o, underrun);
    end
    cen_pulse(o, v);
    total++;
    if (o !== 16'sd200 || v !== 1'b1 || underrun !== 1'b1) begin
      bad++;
      $display("FAIL udr_empty: got %0d v=%b u=%b want 200 v=1 u=1", o, v, underrun);
    end
    send(16'sd300);
    cen_pulse(o, v);
    total++;
    if (o !== 16'sd200 || v !== 1'b1) begin
      bad++;
      $display("FAIL udr_prime_hold: got %0d v=%b want 200 v=1", o, v);
    end
    send(16'sd300);
    cen_pulse(o, v);
    total++;
    if (o !== 16'sd300 || underrun !== 1'b1) begin
      bad++;
      $display("FAIL udr_restart: got %0d u=%b want 300 u=1", o, underrun);
    end
  endtask

  task automatic test_overrun();
    logic signed [15:0] o;
    logic v;
    do_reset();
    gain = 8'h10;
    for (int i = 1; i <= 5; i++) send(16'(i * 10));
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_full: got %b want 1", overrun); end
    for (int i = 1; i <= 4; i++) begin
      cen_pulse(o, v);
      total++;
      if (o !== 16'(i * 10)) begin
        bad++;
        $display("FAIL ovr_pop%0d: got %0d want %0d", i, o, i * 10);
      end
    end
    pulse_clr();
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr: got %b want 0", overrun); end
    sound_in = 16'sd60;
    sample = 1'b1;
    tick();
    sample = 1'b0;
    tick();
    sample = 1'b1;
    tick();
    sample = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_spacing: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] o;
    logic v;
    do_reset();
    gain = 8'h10;
    sound_in = 16'sd777;
    sample = 1'b1;
    tick();
    sample = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    cen_pulse(o, v);
    total++;
    if (o !== 16'sd0 || v !== 1'b1 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_cen: got %0d v=%b u=%b want 0 v=1 u=0", o, v, underrun);
    end
    send(16'sd500);
    send(16'sd500);
    cen_pulse(o, v);
    total++;
    if (o !== 16'sd500) begin
      bad++;
      $display("FAIL mid_rst_state: got %0d want 500", o);
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_saturation();
    test_underrun();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
